reg_wr_arbiter: RTL

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

---
 rtl/reg_ctrl_pkg.sv | 17 +
 rtl/rr_arb2.sv | 55 +++++
 rtl/reg_wr_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/reg_ctrl_pkg.sv
// Shared types and constants for the register-write arbiter slice.
package reg_ctrl_pkg;

    localparam int NUM_REQ   = 2;
    localparam int REQ_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    localparam req_idx_t REQ_IDX_0 = req_idx_t'(0);
    localparam req_idx_t REQ_IDX_1 = req_idx_t'(1);

    // The opposite requester of a two-way pair.
    function automatic req_idx_t other_req(input req_idx_t idx);
        return (idx == REQ_IDX_0) ? REQ_IDX_1 : REQ_IDX_0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from a valid vector, pointer
// advances only when a grant is issued.
module rr_arb2
    import reg_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               upd_o
);

    req_idx_t ptr_q;
    req_idx_t ptr_d;
    req_idx_t win_s;

    // Grant selection; ptr_q names the requester favoured on contention.
    always_comb begin
        grant_o = {NUM_REQ{1'b0}};
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11: begin
                if (ptr_q == REQ_IDX_0) begin
                    grant_o = 2'b01;
                end else begin
                    grant_o = 2'b10;
                end
            end
            default: grant_o = 2'b00;
        endcase
    end

    // Next pointer: after a grant, favour the requester that lost.
    always_comb begin
        upd_o = |grant_o;
        win_s = grant_o[1] ? REQ_IDX_1 : REQ_IDX_0;
        ptr_d = ptr_q;
        if (upd_o) begin
            ptr_d = other_req(win_s);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_IDX_0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Arbitrates two register-file write requesters onto one registered write
// port and keeps a per-register pending-write scoreboard.
module reg_wr_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req_valid_0,
    output logic                     req_ready_0,
    input  logic [ADDR_WIDTH-1:0]    req_addr_0,
    input  logic [DATA_WIDTH-1:0]    req_data_0,

    input  logic                     req_valid_1,
    output logic                     req_ready_1,
    input  logic [ADDR_WIDTH-1:0]    req_addr_1,
    input  logic [DATA_WIDTH-1:0]    req_data_1,

    input  logic                     rsv_valid,
    input  logic [ADDR_WIDTH-1:0]    rsv_addr,

    output logic                     wr_en,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic [2**ADDR_WIDTH-1:0] busy
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    logic [NUM_REQ-1:0]    valid_s;
    logic [NUM_REQ-1:0]    grant_s;
    logic                  xfer_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_data_s;

    logic                  wr_en_q,   wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0]   busy_q,    busy_d;

    // Masking with rst_n keeps ready low for the whole reset, clock or not.
    assign valid_s = {req_valid_1, req_valid_0} & {NUM_REQ{rst_n}};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_s),
        .grant_o (grant_s),
        .upd_o   (xfer_s)
    );

    assign req_ready_0 = grant_s[0];
    assign req_ready_1 = grant_s[1];

    // Steer the granted requester's address and data.
    always_comb begin
        sel_addr_s = req_addr_0;
        sel_data_s = req_data_0;
        if (grant_s[1]) begin
            sel_addr_s = req_addr_1;
            sel_data_s = req_data_1;
        end else begin
            sel_addr_s = req_addr_0;
            sel_data_s = req_data_0;
        end
    end

    // Write-port next state: address and data hold between writes.
    always_comb begin
        wr_en_d   = xfer_s;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (xfer_s) begin
            wr_addr_d = sel_addr_s;
            wr_data_d = sel_data_s;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    // Scoreboard next state; a reserve outranks a clear on the same register.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rsv_valid && (rsv_addr == ADDR_WIDTH'(r))) begin
                busy_d[r] = 1'b1;
            end else if (xfer_s && (sel_addr_s == ADDR_WIDTH'(r))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
    end

    // Output and scoreboard registers; reset drops any write still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDR_WIDTH{1'b0}};
            wr_data_q <= {DATA_WIDTH{1'b0}};
            busy_q    <= {NUM_REGS{1'b0}};
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

endmodule
